eth_phy_10g_tx_hdr_inject: RTL and testbench
============================================

# eth_phy_10g_tx_hdr_inject

Transmit-side sync-header error injector for the 10G BASE-R PHY, placed between the 64b/66b encoder output and the SERDES TX interface. It passes data and headers through a single register stage. On command, it replaces valid sync headers with invalid ones at a programmed count per 125 µs window, or as single-shot events. This exercises the far-end receiver's block-lock and high-BER detection (16 invalid headers per window triggers high BER).

## Interface
- DATA_WIDTH, 64, TX data width; only 64 is legal (elaboration error otherwise)
- HDR_WIDTH, 2, sync header width; only 2 is legal
- COUNT_125US, 125000/6.4, clock cycles per 125 µs window; must be > 32 (elaboration error otherwise)
- clk  input  1  clock; all logic is on the rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- encoded_tx_data  input  DATA_WIDTH  encoder data
- encoded_tx_hdr  input  HDR_WIDTH  encoder sync header
- serdes_tx_data  output  DATA_WIDTH  registered data to SERDES
- serdes_tx_hdr  output  HDR_WIDTH  registered, possibly corrupted header to SERDES
- cfg_enable  input  1  level; enables windowed injection
- cfg_err_count  input  5  invalid headers per window, 0–31; sampled at window start
- cfg_single_req  input  1  pulse; requests one injected error
- cfg_clear  input  1  pulse; clears err_total
- single_ack  output  1  one-cycle pulse, coincident with the single-shot corrupted header at the output
- inject_flag  output  1  high in exactly the cycles where serdes_tx_hdr is corrupted
- err_total  output  32  saturating count of injected errors

## Operation
- **Datapath.** Each cycle, serdes_tx_data <= encoded_tx_data. serdes_tx_hdr <= encoded_tx_hdr, or <= the corruption value when injecting.
- **Corruption value.** Alternates 2'b00 and 2'b11. The first value after reset is 2'b00. It toggles after each injected error, from either source.
- **Injection applies regardless of input header value.** Data is never modified.
- **State machine: IDLE, BURST, WAIT.**
  - IDLE: timer held at COUNT_125US. When cfg_enable = 1:
    - load remaining = cfg_err_count;
    - go to BURST if the count is nonzero, else go to WAIT.
  - BURST: inject every cycle and decrement remaining. When remaining reaches 1 on an injecting cycle, go to WAIT.
  - WAIT: no windowed injection.
  - BURST and WAIT both decrement the timer each cycle. When timer == 0:
    - reload COUNT_125US;
    - resample cfg_err_count into remaining;
    - go to BURST if the count is nonzero, else stay in WAIT.
  - cfg_enable = 0 in BURST or WAIT: go to IDLE next cycle with no injection in that cycle. Any unfinished burst is discarded.
- **Config changes.** Changing cfg_err_count mid-window affects only the next window.
- **Single shot.**
  - cfg_single_req sets a pending flag; it works regardless of cfg_enable.
  - The pending request is injected on the first cycle not in BURST.
  - A req while pending merges into the one pending request; it is not queued.
  - A req in the same cycle that a pending request is injected sets a new pending flag.
- **err_total.**
  - Increments by 1 per injected header and saturates at 32'hFFFFFFFF.
  - cfg_clear with a simultaneous injection gives err_total = 1.

## Timing
- **Reset values.** serdes_tx_data = 0, serdes_tx_hdr = 2'b01, single_ack = 0, inject_flag = 0, err_total = 0. State is IDLE, pending = 0, corruption value = 2'b00, timer = COUNT_125US.
- **Latency.** One cycle, input to output, for data and header. inject_flag, single_ack and err_total update on the same edge as the corrupted header.
- **First injection.** cfg_enable sampled high at edge N (IDLE) gives the first corrupted output after edge N+1.
- **Window period.** Exactly COUNT_125US+1 cycles between burst starts, matching the receiver's window period.
- **Reset mid-burst.** Outputs take their reset values asynchronously. The pending single shot is lost.

## Test plan
- Reset, stream valid headers, no cfg -> output equals input delayed 1 cycle; inject_flag, single_ack and err_total stay 0.
- cfg_err_count = 5, cfg_enable = 1 for 3 windows -> 5 consecutive corrupted headers (00, 11, 00, 11, 00, then continuing to alternate) at the start of each window, every COUNT_125US+1 cycles; err_total = 15.
- cfg_err_count = 16 into the receive BER monitor loopback -> far-end rx_high_ber asserts. With cfg_err_count = 15 -> rx_high_ber stays 0.
- cfg_single_req pulse during BURST of 4 -> single-shot corruption occurs in the cycle after the burst ends; single_ack = 1 for that cycle only; inject_flag high for 5 consecutive cycles.
- Drop cfg_enable after 2 of 10 burst errors -> no further corruption; err_total = 2. Re-enable -> new burst of cfg_err_count starts with a full window.
- err_total preset near saturation by a long run (forced) -> holds at 32'hFFFFFFFF. cfg_clear with a concurrent injection -> 1. rst_n low mid-burst -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/eth_phy_10g_tx_hdr_inject.sv
// Transmit-side sync-header error injector for the 10G BASE-R PHY.
// Sits between the 64b/66b encoder and the SERDES TX interface and
// registers data and header once. On command it replaces sync headers
// with invalid ones (alternating 00 / 11). There are two sources:
//   - windowed: a burst of cfg_err_count headers at the start of each
//     COUNT_125US+1 cycle window while cfg_enable is high
//   - single shot: one header per cfg_single_req, deferred past any burst
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   encoded_tx_data/hdr              encoder output
//   serdes_tx_data/hdr               registered output to SERDES
//   cfg_enable, cfg_err_count        windowed injection control
//   cfg_single_req                   single-shot request pulse
//   cfg_clear                        clears err_total
//   single_ack                       pulse with the single-shot header
//   inject_flag                      high with every corrupted header
//   err_total                        saturating injected-error count
module eth_phy_10g_tx_hdr_inject #(
  parameter int DATA_WIDTH  = 64,
  parameter int HDR_WIDTH   = 2,
  parameter int COUNT_125US = 19531   // 125 us / 6.4 ns
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] encoded_tx_data,
  input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
  output logic [DATA_WIDTH-1:0] serdes_tx_data,
  output logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
  input  logic                  cfg_enable,
  input  logic [4:0]            cfg_err_count,
  input  logic                  cfg_single_req,
  input  logic                  cfg_clear,
  output logic                  single_ack,
  output logic                  inject_flag,
  output logic [31:0]           err_total
);

  if (DATA_WIDTH != 64) begin : g_bad_data_width
    $error("eth_phy_10g_tx_hdr_inject: DATA_WIDTH must be 64");
  end
  if (HDR_WIDTH != 2) begin : g_bad_hdr_width
    $error("eth_phy_10g_tx_hdr_inject: HDR_WIDTH must be 2");
  end
  if (COUNT_125US <= 32) begin : g_bad_count
    $error("eth_phy_10g_tx_hdr_inject: COUNT_125US must exceed 32");
  end

  localparam int TW = $clog2(COUNT_125US + 1);
  localparam logic [TW-1:0] TIMER_INIT = TW'(COUNT_125US);

  typedef enum logic [1:0] {IDLE, BURST, WAIT} state_t;

  state_t        state, state_n;
  logic [4:0]    remaining, remaining_n;
  logic [TW-1:0] timer, timer_n;
  logic          pending;
  logic          corr_sel;    // 0 -> next corruption is 00, 1 -> 11
  logic          burst_inj;
  logic          single_inj;
  logic          inject;

  // Single shot never collides with a burst: it waits for a non-BURST cycle.
  assign single_inj = pending && (state != BURST);
  assign inject     = burst_inj | single_inj;

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    timer_n     = timer;
    burst_inj   = 1'b0;
    case (state)
      IDLE: begin
        timer_n = TIMER_INIT;
        if (cfg_enable) begin
          remaining_n = cfg_err_count;
          state_n     = (cfg_err_count != 5'd0) ? BURST : WAIT;
        end
      end
      BURST, WAIT: begin
        if (!cfg_enable) begin
          // Drop out immediately; an unfinished burst is discarded.
          state_n = IDLE;
          timer_n = TIMER_INIT;
        end else if (timer == '0) begin
          // Window boundary: count sampled here only, so mid-window
          // cfg_err_count changes land in the next window.
          timer_n     = TIMER_INIT;
          remaining_n = cfg_err_count;
          state_n     = (cfg_err_count != 5'd0) ? BURST : WAIT;
        end else begin
          timer_n = timer - TW'(1);
          if (state == BURST) begin
            burst_inj   = 1'b1;
            remaining_n = remaining - 5'd1;
            if (remaining == 5'd1) state_n = WAIT;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      remaining      <= 5'd0;
      timer          <= TIMER_INIT;
      pending        <= 1'b0;
      corr_sel       <= 1'b0;
      serdes_tx_data <= '0;
      serdes_tx_hdr  <= HDR_WIDTH'(1);
      single_ack     <= 1'b0;
      inject_flag    <= 1'b0;
      err_total      <= 32'd0;
    end else begin
      state          <= state_n;
      remaining      <= remaining_n;
      timer          <= timer_n;
      // A request arriving as the pending one fires re-arms the flag.
      pending        <= cfg_single_req | (pending & ~single_inj);
      if (inject) corr_sel <= ~corr_sel;
      serdes_tx_data <= encoded_tx_data;
      serdes_tx_hdr  <= inject ? {HDR_WIDTH{corr_sel}} : encoded_tx_hdr;
      single_ack     <= single_inj;
      inject_flag    <= inject;
      if (cfg_clear)
        err_total <= {31'd0, inject};
      else if (inject && (err_total != 32'hFFFF_FFFF))
        err_total <= err_total + 32'd1;
    end
  end

endmodule

// File: tb/tb_eth_phy_10g_tx_hdr_inject.sv
// Self-checking bench for eth_phy_10g_tx_hdr_inject. A window-position
// model predicts every output each cycle; directed phases pin the model
// with literal expectations, then a randomized phase runs against it.
module tb_eth_phy_10g_tx_hdr_inject;
  localparam int CNT = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] encoded_tx_data;
  logic [1:0]  encoded_tx_hdr;
  logic [63:0] serdes_tx_data;
  logic [1:0]  serdes_tx_hdr;
  logic        cfg_enable;
  logic [4:0]  cfg_err_count;
  logic        cfg_single_req;
  logic        cfg_clear;
  logic        single_ack;
  logic        inject_flag;
  logic [31:0] err_total;

  eth_phy_10g_tx_hdr_inject #(.DATA_WIDTH(64), .HDR_WIDTH(2), .COUNT_125US(CNT)) dut (
    .clk(clk), .rst_n(rst_n),
    .encoded_tx_data(encoded_tx_data), .encoded_tx_hdr(encoded_tx_hdr),
    .serdes_tx_data(serdes_tx_data), .serdes_tx_hdr(serdes_tx_hdr),
    .cfg_enable(cfg_enable), .cfg_err_count(cfg_err_count),
    .cfg_single_req(cfg_single_req), .cfg_clear(cfg_clear),
    .single_ack(single_ack), .inject_flag(inject_flag), .err_total(err_total)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: pos is the cycle index inside the current window (-1 = idle),
  // n the error count sampled for that window.
  int          pos, n;
  bit          pend, corr;
  logic [31:0] m_total;
  logic [63:0] e_data;
  logic [1:0]  e_hdr;
  logic        e_flag, e_ack;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos = -1; n = 0; pend = 1'b0; corr = 1'b0; m_total = 32'd0;
    e_data = 64'd0; e_hdr = 2'b01; e_flag = 1'b0; e_ack = 1'b0;
  endtask

  // Predict outputs after the coming rising edge from the current inputs.
  task automatic model_step();
    bit in_burst, fire, inj;
    in_burst = (pos >= 0) && (pos < n);
    fire     = pend && !in_burst;
    inj      = (in_burst && cfg_enable) || fire;
    e_data   = encoded_tx_data;
    e_hdr    = inj ? (corr ? 2'b11 : 2'b00) : encoded_tx_hdr;
    e_flag   = inj;
    e_ack    = fire;
    if (cfg_clear) m_total = inj ? 32'd1 : 32'd0;
    else if (inj && m_total != 32'hFFFF_FFFF) m_total = m_total + 32'd1;
    if (inj) corr = !corr;
    pend = cfg_single_req || (pend && !fire);
    if (pos < 0) begin
      if (cfg_enable) begin n = cfg_err_count; pos = 0; end
    end else if (!cfg_enable) pos = -1;
    else if (pos == CNT) begin n = cfg_err_count; pos = 0; end
    else pos++;
  endtask

  task automatic compare();
    chk("data", serdes_tx_data, e_data);
    chk("hdr", {62'd0, serdes_tx_hdr}, {62'd0, e_hdr});
    chk("inject_flag", {63'd0, inject_flag}, {63'd0, e_flag});
    chk("single_ack", {63'd0, single_ack}, {63'd0, e_ack});
    chk("err_total", {32'd0, err_total}, {32'd0, m_total});
  endtask

  // One clock: predict, wait for the edge, check at the falling edge,
  // then drop pulses and present fresh data.
  task automatic cyc();
    model_step();
    @(negedge clk);
    compare();
    cfg_single_req  = 1'b0;
    cfg_clear       = 1'b0;
    encoded_tx_data = {$urandom, $urandom};
    encoded_tx_hdr  = 2'($urandom_range(0, 3));
  endtask

  initial begin
    int fl, ackpos;
    rst_n = 1'b0; cfg_enable = 1'b0; cfg_err_count = 5'd0;
    cfg_single_req = 1'b0; cfg_clear = 1'b0;
    encoded_tx_data = 64'h0123_4567_89AB_CDEF; encoded_tx_hdr = 2'b10;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_data", serdes_tx_data, 64'd0);
    chk("rst_hdr", {62'd0, serdes_tx_hdr}, 64'd1);
    chk("rst_flag", {63'd0, inject_flag}, 64'd0);
    chk("rst_ack", {63'd0, single_ack}, 64'd0);
    chk("rst_total", {32'd0, err_total}, 64'd0);
    rst_n = 1'b1;

    // Pass-through with valid headers only.
    repeat (20) begin
      encoded_tx_hdr = 2'($urandom_range(1, 2));
      cyc();
    end
    chk("pass_total", {32'd0, err_total}, 64'd0);

    // Count 5 for three windows.
    cfg_enable = 1'b1; cfg_err_count = 5'd5;
    cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("burst5_hdr", {62'd0, serdes_tx_hdr}, (i % 2 == 1) ? 64'd3 : 64'd0);
    end
    repeat (3 * (CNT + 1) - 5) cyc();
    chk("three_windows_total", {32'd0, err_total}, 64'd15);
    cfg_enable = 1'b0;
    repeat (2) cyc();

    // Single shot requested during a burst of 4.
    cfg_enable = 1'b1; cfg_err_count = 5'd4;
    cyc();
    fl = 0; ackpos = -1;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) cfg_single_req = 1'b1;
      cyc();
      if (inject_flag) fl++;
      if (single_ack) ackpos = (ackpos == -1) ? i : 99;
    end
    chk("burst4_flags", 64'(fl), 64'd5);
    chk("burst4_ack_pos", 64'(ackpos), 64'd4);
    cfg_enable = 1'b0;
    repeat (2) cyc();

    // Drop enable after 2 of 10.
    cfg_clear = 1'b1;
    cyc();
    cfg_enable = 1'b1; cfg_err_count = 5'd10;
    repeat (3) cyc();
    cfg_enable = 1'b0;
    repeat (4) cyc();
    chk("drop_total", {32'd0, err_total}, 64'd2);
    cfg_enable = 1'b1; cfg_err_count = 5'd3;
    repeat (2 * (CNT + 1) + 5) cyc();
    cfg_enable = 1'b0;
    repeat (2) cyc();

    // Saturation, then clear with a concurrent single-shot injection.
    force dut.err_total = 32'hFFFF_FFFD;
    #1 release dut.err_total;
    m_total = 32'hFFFF_FFFD;
    cfg_enable = 1'b1; cfg_err_count = 5'd5;
    repeat (6) cyc();
    chk("sat_total", {32'd0, err_total}, 64'hFFFF_FFFF);
    cfg_single_req = 1'b1;
    cyc();
    cfg_clear = 1'b1;
    cyc();
    chk("clear_inj_total", {32'd0, err_total}, 64'd1);
    chk("clear_inj_ack", {63'd0, single_ack}, 64'd1);
    cfg_enable = 1'b0;
    repeat (2) cyc();

    // Reset in the middle of a burst with a single shot pending.
    cfg_enable = 1'b1; cfg_err_count = 5'd20;
    repeat (2) cyc();
    cfg_single_req = 1'b1;
    repeat (2) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_data", serdes_tx_data, 64'd0);
    chk("midrst_hdr", {62'd0, serdes_tx_hdr}, 64'd1);
    chk("midrst_flag", {63'd0, inject_flag}, 64'd0);
    chk("midrst_ack", {63'd0, single_ack}, 64'd0);
    chk("midrst_total", {32'd0, err_total}, 64'd0);
    model_reset();
    cfg_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cyc();

    // Randomized traffic and configuration.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 199) == 0) cfg_enable = ~cfg_enable;
      if ($urandom_range(0, 59) == 0) cfg_err_count = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 29) == 0) cfg_single_req = 1'b1;
      if ($urandom_range(0, 149) == 0) cfg_clear = 1'b1;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
